// File: rtl/inst_pc_ctrl_pkg.sv
// inst_pc_ctrl_pkg: shared types and constants
// for the instruction PC sequencer.
package inst_pc_ctrl_pkg;

  typedef enum logic {
    PC_IDLE = 1'b0,
    PC_RUN  = 1'b1
  } pc_state_e;

  localparam int unsigned NumLoopLevels = 3;

  localparam logic [1:0] LOOP_MODE_LINEAR = 2'd0;
  localparam logic [1:0] LOOP_MODE_ONE    = 2'd1;
  localparam logic [1:0] LOOP_MODE_TWO    = 2'd2;
  localparam logic [1:0] LOOP_MODE_THREE  = 2'd3;

endpackage

// File: rtl/inst_pc_ctrl_loop.sv
// loop_level_cnt: one hardware loop level with
// latched jump/end/count and its iteration counter.
module loop_level_cnt #(
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [AddrWidth-1:0] jump_i,
  input  logic [AddrWidth-1:0] end_i,
  input  logic [AddrWidth-1:0] count_i,
  input  logic [AddrWidth-1:0] pc_i,
  input  logic                 inc_i,
  input  logic                 clr_iter_i,
  output logic                 hit_o,
  output logic                 take_jump_o,
  output logic                 exhausted_o,
  output logic [AddrWidth-1:0] jump_o
);

  logic [AddrWidth-1:0] jump_q;
  logic [AddrWidth-1:0] end_q;
  logic [AddrWidth-1:0] cnt_q;
  logic [AddrWidth-1:0] iter_q;
  logic [AddrWidth:0]   iter_nx;

  // One extra bit so iter+1 cannot wrap.
  assign iter_nx     = {1'b0, iter_q}
                     + (AddrWidth+1)'(1);
  assign hit_o       = (pc_i == end_q);
  assign take_jump_o = hit_o
                     && (iter_nx < {1'b0, cnt_q});
  assign exhausted_o = hit_o && !take_jump_o;
  assign jump_o      = jump_q;

  // Config latch, captured on start only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      jump_q <= '0;
      end_q  <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      jump_q <= jump_i;
      end_q  <= end_i;
      cnt_q  <= count_i;
    end
  end

  // Iteration counter; clear beats increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iter_q <= '0;
    end else if (clr_iter_i) begin
      iter_q <= '0;
    end else if (inc_i) begin
      iter_q <= iter_q + AddrWidth'(1);
    end
  end

endmodule

// File: rtl/inst_pc_ctrl.sv
// inst_pc_ctrl: PC sequencer with up to three
// nested hardware loops, stall hold and done pulse.
module inst_pc_ctrl
  import inst_pc_ctrl_pkg::*;
#(
  parameter int unsigned InstMemDepth     = 32,
  parameter int unsigned InstMemAddrWidth =
    $clog2(InstMemDepth)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        clr_i,
  input  logic                        stall_i,
  input  logic [1:0]                  loop_mode_i,
  input  logic [InstMemAddrWidth-1:0] loop_jump_addr1_i,
  input  logic [InstMemAddrWidth-1:0] loop_jump_addr2_i,
  input  logic [InstMemAddrWidth-1:0] loop_jump_addr3_i,
  input  logic [InstMemAddrWidth-1:0] loop_end_addr1_i,
  input  logic [InstMemAddrWidth-1:0] loop_end_addr2_i,
  input  logic [InstMemAddrWidth-1:0] loop_end_addr3_i,
  input  logic [InstMemAddrWidth-1:0] loop_count1_i,
  input  logic [InstMemAddrWidth-1:0] loop_count2_i,
  input  logic [InstMemAddrWidth-1:0] loop_count3_i,
  output logic [InstMemAddrWidth-1:0] inst_pc_o,
  output logic                        inst_valid_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned AW = InstMemAddrWidth;
  localparam logic [AW-1:0] TopAddr =
    AW'(InstMemDepth - 1);

  pc_state_e state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [1:0]    mode_q;
  logic          done_q, done_d;

  logic [AW-1:0] jmp_in [NumLoopLevels];
  logic [AW-1:0] end_in [NumLoopLevels];
  logic [AW-1:0] cnt_in [NumLoopLevels];
  logic [AW-1:0] jmp_lv [NumLoopLevels];

  logic [NumLoopLevels-1:0] lv_hit;
  logic [NumLoopLevels-1:0] lv_take;
  logic [NumLoopLevels-1:0] lv_exh;
  logic [NumLoopLevels-1:0] eval;
  logic [NumLoopLevels-1:0] take;
  logic [NumLoopLevels-1:0] inc;
  logic [NumLoopLevels-1:0] clr_iter;

  logic          adv;
  logic          blocked;
  logic          jump_any;
  logic [AW-1:0] jump_pc;
  logic          fin_hit;
  logic          do_start;
  logic          do_jump;
  logic          do_fin;
  logic          do_step;
  logic          load;

  assign jmp_in[0] = loop_jump_addr1_i;
  assign jmp_in[1] = loop_jump_addr2_i;
  assign jmp_in[2] = loop_jump_addr3_i;
  assign end_in[0] = loop_end_addr1_i;
  assign end_in[1] = loop_end_addr2_i;
  assign end_in[2] = loop_end_addr3_i;
  assign cnt_in[0] = loop_count1_i;
  assign cnt_in[1] = loop_count2_i;
  assign cnt_in[2] = loop_count3_i;

  for (genvar g = 0; g < NumLoopLevels; g++) begin : g_lvl
    loop_level_cnt #(
      .AddrWidth(AW)
    ) u_lvl (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (load),
      .jump_i     (jmp_in[g]),
      .end_i      (end_in[g]),
      .count_i    (cnt_in[g]),
      .pc_i       (pc_q),
      .inc_i      (inc[g]),
      .clr_iter_i (clr_iter[g]),
      .hit_o      (lv_hit[g]),
      .take_jump_o(lv_take[g]),
      .exhausted_o(lv_exh[g]),
      .jump_o     (jmp_lv[g])
    );
  end

  assign adv = (state_q == PC_RUN)
            && !stall_i && !clr_i;

  // Inner-first loop priority; first taken jump wins.
  always_comb begin
    eval    = '0;
    take    = '0;
    blocked = 1'b0;
    jump_pc = '0;
    for (int k = 0; k < NumLoopLevels; k++) begin
      if (k < int'(mode_q) && !blocked) begin
        eval[k] = 1'b1;
        if (lv_take[k]) begin
          take[k] = 1'b1;
          jump_pc = jmp_lv[k];
          blocked = 1'b1;
        end
      end
    end
  end

  assign jump_any = |take;

  // Last instruction of the program for this mode.
  always_comb begin
    fin_hit = 1'b0;
    unique case (mode_q)
      LOOP_MODE_LINEAR: fin_hit = (pc_q == TopAddr);
      LOOP_MODE_ONE:    fin_hit = lv_hit[0];
      LOOP_MODE_TWO:    fin_hit = lv_hit[1];
      LOOP_MODE_THREE:  fin_hit = lv_hit[2];
      default:          fin_hit = 1'b0;
    endcase
  end

  assign do_start = !clr_i && start_i
                 && (state_q == PC_IDLE);
  assign do_jump  = adv && jump_any;
  assign do_fin   = adv && !jump_any && fin_hit;
  assign do_step  = adv && !jump_any && !fin_hit;
  assign load     = do_start;

  // Per-level counter control.
  always_comb begin
    inc      = '0;
    clr_iter = '0;
    for (int k = 0; k < NumLoopLevels; k++) begin
      inc[k]      = do_jump && take[k];
      clr_iter[k] = clr_i || do_start || do_fin
                 || (adv && eval[k] && lv_exh[k]);
    end
  end

  // Next state, PC and done pulse.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
    unique case (1'b1)
      clr_i: begin
        state_d = PC_IDLE;
        pc_d    = '0;
      end
      do_start: begin
        state_d = PC_RUN;
        pc_d    = '0;
      end
      do_jump: pc_d = jump_pc;
      do_fin: begin
        state_d = PC_IDLE;
        pc_d    = '0;
        done_d  = 1'b1;
      end
      do_step: pc_d = pc_q + AW'(1);
      default: ;
    endcase
  end

  // State, PC, mode latch and done register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PC_IDLE;
      pc_q    <= '0;
      mode_q  <= LOOP_MODE_LINEAR;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      if (load) mode_q <= loop_mode_i;
    end
  end

  assign inst_pc_o    = pc_q;
  assign inst_valid_o = (state_q == PC_RUN);
  assign busy_o       = (state_q == PC_RUN);
  assign done_o       = done_q;

endmodule

// File: tb/tb_inst_pc_ctrl.sv
// tb_inst_pc_ctrl: directed vectors for the
// PC sequencer with hand-computed PC traces.
module tb_inst_pc_ctrl;

  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          clr;
  logic          stall;
  logic [1:0]    mode;
  logic [AW-1:0] j1, j2, j3;
  logic [AW-1:0] e1, e2, e3;
  logic [AW-1:0] c1, c2, c3;
  logic [AW-1:0] pc;
  logic          valid;
  logic          busy;
  logic          done;

  int n_chk;
  int n_fail;
  int exp_q[$];

  inst_pc_ctrl #(
    .InstMemDepth(8)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start),
    .clr_i            (clr),
    .stall_i          (stall),
    .loop_mode_i      (mode),
    .loop_jump_addr1_i(j1),
    .loop_jump_addr2_i(j2),
    .loop_jump_addr3_i(j3),
    .loop_end_addr1_i (e1),
    .loop_end_addr2_i (e2),
    .loop_end_addr3_i (e3),
    .loop_count1_i    (c1),
    .loop_count2_i    (c2),
    .loop_count3_i    (c3),
    .inst_pc_o        (pc),
    .inst_valid_o     (valid),
    .busy_o           (busy),
    .done_o           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int got,
                     input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int m,
                     input int a1, input int b1,
                     input int n1, input int a2,
                     input int b2, input int n2);
    mode = 2'(m);
    j1 = AW'(a1); e1 = AW'(b1); c1 = AW'(n1);
    j2 = AW'(a2); e2 = AW'(b2); c2 = AW'(n2);
    j3 = '0; e3 = '0; c3 = '0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble inputs: latched config must rule.
    mode = 2'd3;
    j1 = 3'd7; e1 = 3'd0; c1 = 3'd7;
    j2 = 3'd7; e2 = 3'd0; c2 = 3'd7;
    j3 = 3'd7; e3 = 3'd0; c3 = 3'd7;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_pc"}, int'(pc), 0);
  endtask

  // Walk exp_q, optional 3-cycle stall at index sidx.
  task automatic run_seq(input string tag,
                         input int sidx);
    go();
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_v%0d", tag, i),
          int'(valid), 1);
      chk($sformatf("%s_pc%0d", tag, i),
          int'(pc), exp_q[i]);
      if (i == sidx) begin
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk($sformatf("%s_st%0d", tag, s),
              int'(pc), exp_q[i]);
          chk($sformatf("%s_stb%0d", tag, s),
              int'(busy), 1);
        end
        stall = 1'b0;
      end
      tick();
    end
    chk({tag, "_done"}, int'(done), 1);
    idle_chk({tag, "_end"});
    tick();
    chk({tag, "_done_off"}, int'(done), 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    clr    = 1'b0;
    stall  = 1'b0;
    cfg(0, 0, 0, 0, 0, 0, 0);
    #12;
    idle_chk("rst");
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    cfg(0, 0, 0, 0, 0, 0, 0);
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_seq("lin", -1);

    cfg(1, 2, 4, 3, 0, 0, 0);
    exp_q = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4};
    run_seq("one", -1);

    cfg(2, 1, 2, 2, 0, 3, 2);
    exp_q = '{0, 1, 2, 1, 2, 3,
              0, 1, 2, 1, 2, 3};
    run_seq("nest", -1);

    cfg(2, 1, 2, 2, 0, 2, 2);
    exp_q = '{0, 1, 2, 1, 2, 0, 1, 2, 1, 2};
    run_seq("shr", -1);

    cfg(1, 2, 4, 3, 0, 0, 0);
    exp_q = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4};
    run_seq("stl", 6);

    // Start while busy ignored, then clear.
    cfg(0, 0, 0, 0, 0, 0, 0);
    go();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("clr_pc%0d", i), int'(pc), i);
      if (i == 5) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("clr_pc6", int'(pc), 6);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    idle_chk("clr");
    chk("clr_done", int'(done), 0);
    tick();
    chk("clr_done2", int'(done), 0);

    cfg(1, 2, 4, 3, 0, 0, 0);
    exp_q = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4};
    run_seq("re", -1);

    // Async reset mid-loop, off the clock edge.
    cfg(1, 2, 4, 3, 0, 0, 0);
    go();
    repeat (6) tick();
    chk("ar_pre_pc", int'(pc), 3);
    #2;
    rst_n = 1'b0;
    #1;
    idle_chk("ar");
    chk("ar_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    cfg(1, 2, 4, 3, 0, 0, 0);
    exp_q = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4};
    run_seq("post", -1);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_pc_ctrl.md
Name: inst_pc_ctrl

Overview:
- Program-counter sequencer for the HDC core's instruction memory.
- Steps the PC from 0 on a start pulse and applies up to three nested hardware loops (jump/end/count per level) supplied by the CSR block.
- Holds the PC on datapath stall, raises busy while running, and pulses done after the last instruction is accepted.
- Sits between the CSR block (start, clear, loop config) and the instruction memory read port / decoder.

Parameters:
- InstMemDepth, 32, number of instruction memory words.
- InstMemAddrWidth, $clog2(InstMemDepth), PC, loop address and loop count width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start pulse from CSR
- clr_i  in  1  synchronous abort/clear pulse from CSR
- stall_i  in  1  datapath not ready; PC holds
- loop_mode_i  in  2  0 linear, 1/2/3 = number of active nested loop levels
- loop_jump_addr{1,2,3}_i  in  InstMemAddrWidth each  loop start address; level 1 is innermost
- loop_end_addr{1,2,3}_i  in  InstMemAddrWidth each  last address of the loop body
- loop_count{1,2,3}_i  in  InstMemAddrWidth each  total passes per level; 0 and 1 both mean a single pass
- inst_pc_o  out  InstMemAddrWidth  current PC
- inst_valid_o  out  1  PC is a valid fetch address
- busy_o  out  1  sequencer running
- done_o  out  1  one-cycle pulse on program completion

Behaviour:
- Reset: state IDLE; inst_pc_o=0, inst_valid_o=0, busy_o=0, done_o=0; iteration counters iter1..3=0; latched config=0.
- States: IDLE, RUN.
  - IDLE->RUN on start_i && !clr_i.
  - RUN->IDLE on the finish condition or on clr_i.
- Start latency: start_i high in cycle t gives RUN, inst_pc_o=0, inst_valid_o=1, busy_o=1 from cycle t+1.
- Config latch: on start, latch loop_mode, jump/end/count for all levels. Config input changes during RUN have no effect.
- RUN, inst_valid_o=1:
  - Advance only in cycles with stall_i=0.
  - With stall_i=1, PC, counters and state all hold.
- Advance evaluation at PC p, levels k=1..mode in order:
  - If p==end_k and iter_k+1 < count_k: next PC = jump_k, iter_k++. Stop evaluating.
  - Else if p==end_k (exhausted): iter_k=0, continue to level k+1.
  - Otherwise skip the level.
- No jump taken:
  - Finish condition: mode 0 and p==InstMemDepth-1; or mode>0 and p==end_{mode}.
  - If not finishing, next PC = p+1. Wrap-around is impossible because mode 0 finishes at the top address.
- Finish:
  - done_o=1 for exactly the cycle after the final accepted instruction.
  - In that same cycle: state IDLE, busy_o=0, inst_valid_o=0, inst_pc_o=0, iter*=0.
- Shared end addresses across levels are legal. Inner levels are evaluated first, so nested loops may close on the same instruction.
- Jump addresses greater than the end address are not checked. Behaviour is defined by the rules above (PC increments until the top address, then mode 0 rule does not apply and the PC wraps modulo InstMemDepth). Software must avoid this.
- clr_i:
  - Highest priority in any state.
  - Next cycle: IDLE, PC=0, iter*=0, done_o=0, busy_o=0.
  - start_i in the same cycle is ignored.
- start_i while RUN is ignored.
- Reset mid-run: asynchronous return to the reset values above.
- done_o and start_i coinciding: the new start is accepted only once the state is IDLE (done cycle or later).

Decomposition:
- Package inst_pc_ctrl_pkg:
  - state enum pc_state_e {PC_IDLE, PC_RUN}
  - constant NumLoopLevels=3
  - loop mode encodings LOOP_MODE_LINEAR=0 through 3
- Sub-module loop_level_cnt, instantiated 3 times. Per level it holds:
  - latched jump/end/count
  - iter counter
  - combinational outputs hit (p==end), take_jump, exhausted
  - a clear-iter input
- Top holds the FSM, PC register and priority chain.

Test Plan:
- Linear, InstMemDepth=8, mode 0, start -> PC 0,1,...,7 with inst_valid_o=1; done_o pulse the next cycle; busy_o low, PC=0.
- Single loop, mode 1, jump1=2, end1=4, count1=3 -> PC 0,1,2,3,4,2,3,4,2,3,4; then done_o.
- Nested, mode 2:
  - Distinct ends, jump1=1, end1=2, count1=2, jump2=0, end2=3, count2=2 -> 0,1,2,1,2,3,0,1,2,1,2,3; done_o.
  - Shared end, end2=2 (other fields unchanged) -> 0,1,2,1,2,0,1,2,1,2; done_o.
- Stall: single-loop config, stall_i high for 3 cycles at PC=3 on the second pass -> PC holds 3, iter unchanged; the sequence then resumes identically.
- clr mid-run and start while busy:
  - start_i pulsed at PC=5 -> ignored, sequence unchanged.
  - clr_i at PC=6 -> next cycle busy_o=0, PC=0, no done_o.
  - New start -> sequence from 0 with counters clear.
- Async reset asserted mid-loop -> all outputs to reset values immediately.
